// File: rtl/core_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_pkg
//  Description : Shared types and constants for the unified-memory arbiter.
//                Arbiter state and owner encodings, plus the memory request
//                record at the default widths.
//  Revision    : 1.0  initial release
// ============================================================================
package core_mem_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;
    localparam int c_STRB_W = c_DATA_W / 8;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_RSP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        REQ  = c_ST_REQ,
        RSP  = c_ST_RSP
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
        logic                write;
        logic [c_DATA_W-1:0] wdata;
        logic [c_STRB_W-1:0] wstrb;
    } mem_req_t;

    // The requester that did not win a grant gets priority next time.
    function automatic arb_owner_e other_owner(input arb_owner_e o);
        return (o == OWN_IF) ? OWN_LS : OWN_IF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin grant logic. Purely combinational; the
//                pointer register lives in the parent.
//  Ports       : req[1:0]  request vector (bit 0 = IF, bit 1 = LS)
//                ptr       requester favoured on a conflict
//                advance   a grant is being taken this cycle
//                gnt[1:0]  one-hot grant
//                ptr_nxt   pointer value to register
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import core_mem_pkg::*;
(
    input  logic [1:0] req,
    input  arb_owner_e ptr,
    input  logic       advance,
    output logic [1:0] gnt,
    output arb_owner_e ptr_nxt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr == OWN_IF) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        ptr_nxt = ptr;
        if (advance && (gnt != 2'b00)) begin
            ptr_nxt = other_owner(gnt[1] ? OWN_LS : OWN_IF);
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_arbiter
//  Description : Shares one single-port, variable-latency memory between the
//                instruction-fetch (IF) and load/store (LS) requesters. One
//                transaction outstanding at a time, round-robin arbitration,
//                response routed back to the owning requester, optional
//                response timeout producing an error response.
//  Ports       : clk, rst                     clock, async active-high reset
//                if_req_*/if_addr             IF request channel
//                if_rsp_*                     IF response channel
//                ls_req_*/ls_addr/ls_write/
//                ls_wdata/ls_wstrb            LS request channel
//                ls_rsp_*                     LS response channel
//                mem_req_*/mem_addr/mem_write/
//                mem_wdata/mem_wstrb          memory request channel
//                mem_rsp_valid/mem_rsp_rdata  memory response channel
//  Revision    : 1.0  initial release
// ============================================================================
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RSP_TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_rdata,
    output logic                    if_rsp_err,
    input  logic                    ls_req_valid,
    output logic                    ls_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic                    ls_write,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_wstrb,
    output logic                    ls_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ls_rsp_rdata,
    output logic                    ls_rsp_err,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata
);

    localparam int c_CNT_W = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST =
        c_CNT_W'((RSP_TIMEOUT > 0) ? (RSP_TIMEOUT - 1) : 0);
    localparam bit c_TO_EN = (RSP_TIMEOUT != 0);

    arb_state_e              r_state;
    arb_owner_e              r_owner;
    arb_owner_e              r_rr_ptr;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;

    logic       w_idle;
    logic [1:0] w_gnt;
    arb_owner_e w_ptr_nxt;
    logic       w_rsp_ok;
    logic       w_rsp_to;
    logic       w_rsp_any;

    // Readies are forced low while reset is held so every output is 0.
    assign w_idle = (r_state == IDLE) && !rst;

    rr_arb2 u_rr_arb2 (
        .req     ({ls_req_valid, if_req_valid} & {2{w_idle}}),
        .ptr     (r_rr_ptr),
        .advance (w_idle),
        .gnt     (w_gnt),
        .ptr_nxt (w_ptr_nxt)
    );

    assign if_req_ready = w_gnt[0];
    assign ls_req_ready = w_gnt[1];

    // A real response in the final timeout cycle takes precedence.
    assign w_rsp_ok  = (r_state == RSP) && mem_rsp_valid;
    assign w_rsp_to  = c_TO_EN && (r_state == RSP) && !mem_rsp_valid &&
                       (r_cnt == c_TO_LAST);
    assign w_rsp_any = w_rsp_ok || w_rsp_to;

    assign if_rsp_valid = w_rsp_any && (r_owner == OWN_IF);
    assign ls_rsp_valid = w_rsp_any && (r_owner == OWN_LS);
    assign if_rsp_err   = w_rsp_to  && (r_owner == OWN_IF);
    assign ls_rsp_err   = w_rsp_to  && (r_owner == OWN_LS);
    assign if_rsp_rdata = (w_rsp_ok && (r_owner == OWN_IF)) ? mem_rsp_rdata : '0;
    assign ls_rsp_rdata = (w_rsp_ok && (r_owner == OWN_LS)) ? mem_rsp_rdata : '0;

    assign mem_req_valid = (r_state == REQ);
    assign mem_addr      = r_addr;
    assign mem_write     = r_write;
    assign mem_wdata     = r_wdata;
    assign mem_wstrb     = r_wstrb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= OWN_IF;
            r_rr_ptr <= OWN_IF;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_rr_ptr <= w_ptr_nxt;
                        r_state  <= REQ;
                        if (w_gnt[1]) begin
                            r_owner <= OWN_LS;
                            r_addr  <= ls_addr;
                            r_write <= ls_write;
                            r_wdata <= ls_wdata;
                            r_wstrb <= ls_wstrb;
                        end else begin
                            // Fetches are always full-width reads.
                            r_owner <= OWN_IF;
                            r_addr  <= if_addr;
                            r_write <= 1'b0;
                            r_wdata <= '0;
                            r_wstrb <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_state <= RSP;
                        r_cnt   <= '0;
                    end
                end
                RSP: begin
                    if (w_rsp_any) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_mem_arbiter
//  Description : Self-checking bench for core_mem_arbiter. A transaction-level
//                model predicts grant order and responses; a monitor process
//                compares response strobes against the expected queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_core_mem_arbiter;

    localparam int c_TO = 4;

    typedef struct {
        bit          own_ls;
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    typedef struct {
        bit          own_ls;
        bit          err;
        bit          chk_data;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_addr, if_rsp_rdata;
    logic        ls_req_valid, ls_req_ready, ls_write, ls_rsp_valid, ls_rsp_err;
    logic [31:0] ls_addr, ls_wdata, ls_rsp_rdata;
    logic [3:0]  ls_wstrb;
    logic        mem_req_valid, mem_req_ready, mem_write, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_rdata;
    logic [3:0]  mem_wstrb;

    core_mem_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .RSP_TIMEOUT (c_TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_rdata  (if_rsp_rdata),
        .if_rsp_err    (if_rsp_err),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_addr       (ls_addr),
        .ls_write      (ls_write),
        .ls_wdata      (ls_wdata),
        .ls_wstrb      (ls_wstrb),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rsp_rdata  (ls_rsp_rdata),
        .ls_rsp_err    (ls_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_write     (mem_write),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;

    txn_t q_if[$];
    txn_t q_ls[$];
    rsp_t q_rsp[$];
    txn_t cur;

    // Bench view of the transaction in flight: 0 none, 1 waiting for memory
    // accept, 2 waiting for memory response.
    int          phase      = 0;
    int          stall_left = 0;
    int          rsp_cyc    = 0;
    int          rsp_at     = 0;   // RSP cycle of the memory reply, 0 = never
    bit          last_ls    = 1'b1;
    int          fix_stall  = -1;
    int          fix_k      = -1;
    bit          use_fix_data = 1'b0;
    logic [31:0] fix_data   = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic txn_t mk_if(input logic [31:0] a);
        txn_t t;
        t.own_ls = 1'b0; t.addr = a; t.wr = 1'b0; t.wdata = '0; t.wstrb = '0;
        return t;
    endfunction

    function automatic txn_t mk_ls(input logic [31:0] a, input bit w,
                                   input logic [31:0] d, input logic [3:0] s);
        txn_t t;
        t.own_ls = 1'b1; t.addr = a; t.wr = w; t.wdata = d; t.wstrb = s;
        return t;
    endfunction

    // One clock of stimulus, memory behaviour, and request-side checks.
    task automatic cycle();
        bit          g_if, g_ls;
        logic [31:0] d;
        @(negedge clk);
        if_req_valid = (q_if.size() > 0);
        if_addr      = (q_if.size() > 0) ? q_if[0].addr : 32'h0;
        ls_req_valid = (q_ls.size() > 0);
        ls_addr      = (q_ls.size() > 0) ? q_ls[0].addr  : 32'h0;
        ls_write     = (q_ls.size() > 0) ? q_ls[0].wr    : 1'b0;
        ls_wdata     = (q_ls.size() > 0) ? q_ls[0].wdata : 32'h0;
        ls_wstrb     = (q_ls.size() > 0) ? q_ls[0].wstrb : 4'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = $urandom;
        case (phase)
            0: begin
                mem_req_ready = 1'($urandom_range(0, 1));
                mem_rsp_valid = ($urandom_range(0, 5) == 0);
            end
            1: begin
                mem_req_ready = (stall_left == 0);
                if (stall_left > 0) mem_rsp_valid = ($urandom_range(0, 3) == 0);
            end
            default: begin
                rsp_cyc++;
                if (rsp_cyc == rsp_at) begin
                    d = use_fix_data ? fix_data : 32'($urandom);
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = d;
                    q_rsp.push_back('{cur.own_ls, 1'b0, !cur.wr, d});
                end else if (rsp_at == 0 && rsp_cyc == c_TO) begin
                    q_rsp.push_back('{cur.own_ls, 1'b1, 1'b1, 32'h0});
                end
            end
        endcase
        #1;
        chk("mem_req_valid", mem_req_valid, phase == 1);
        if (phase == 1) begin
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_write_wstrb", {mem_write, mem_wstrb}, {cur.wr, cur.wstrb});
            if (cur.own_ls) chk("mem_wdata", mem_wdata, cur.wdata);
        end
        // Round robin: with both pending, the one not granted last time wins.
        g_if = 1'b0; g_ls = 1'b0;
        if (phase == 0) begin
            if (q_if.size() > 0 && q_ls.size() > 0) begin
                g_ls = !last_ls; g_if = last_ls;
            end else begin
                g_if = (q_if.size() > 0); g_ls = (q_ls.size() > 0);
            end
        end
        chk("req_ready", {if_req_ready, ls_req_ready}, {g_if, g_ls});
        if (phase == 0) begin
            if (g_if || g_ls) begin
                cur        = g_ls ? q_ls.pop_front() : q_if.pop_front();
                last_ls    = g_ls;
                phase      = 1;
                stall_left = (fix_stall >= 0) ? fix_stall : $urandom_range(0, 3);
            end
        end else if (phase == 1) begin
            if (stall_left == 0) begin
                phase   = 2;
                rsp_cyc = 0;
                rsp_at  = (fix_k >= 0) ? fix_k : $urandom_range(0, 4);
            end else begin
                stall_left--;
            end
        end else if (rsp_cyc == rsp_at || (rsp_at == 0 && rsp_cyc == c_TO)) begin
            phase = 0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q_if.size() > 0 || q_ls.size() > 0 || phase != 0) && n < budget) begin
            cycle();
            n++;
        end
        if (q_if.size() > 0 || q_ls.size() > 0 || phase != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_budget: got busy after %0d cycles expected idle", n);
            q_if.delete(); q_ls.delete(); phase = 0;
        end
        repeat (2) cycle();
    endtask

    // Response monitor: every strobe must match the oldest expected response.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (if_rsp_valid || ls_rsp_valid) begin
                chk("rsp_exclusive", {if_rsp_valid, ls_rsp_valid} == 2'b11, 1'b0);
                if (q_rsp.size() == 0) begin
                    chk("rsp_unexpected", {if_rsp_valid, ls_rsp_valid}, 2'b00);
                end else begin
                    e = q_rsp.pop_front();
                    chk("rsp_owner", {if_rsp_valid, ls_rsp_valid}, {!e.own_ls, e.own_ls});
                    if (e.own_ls) begin
                        chk("ls_rsp_err", {ls_rsp_err, if_rsp_err}, {e.err, 1'b0});
                        if (e.chk_data) chk("ls_rsp_rdata", ls_rsp_rdata, e.rdata);
                        chk("if_rdata_quiet", if_rsp_rdata, 32'h0);
                    end else begin
                        chk("if_rsp_err", {if_rsp_err, ls_rsp_err}, {e.err, 1'b0});
                        if (e.chk_data) chk("if_rsp_rdata", if_rsp_rdata, e.rdata);
                        chk("ls_rdata_quiet", ls_rsp_rdata, 32'h0);
                    end
                end
            end else begin
                chk("rsp_quiet", {if_rsp_err, ls_rsp_err, if_rsp_rdata, ls_rsp_rdata}, 66'h0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        if_req_valid = 0; if_addr = 0; ls_req_valid = 0; ls_addr = 0;
        ls_write = 0; ls_wdata = 0; ls_wstrb = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
                           if_rsp_err, ls_rsp_err, mem_req_valid, mem_write, mem_wstrb}, 0);
        chk("reset_mem_data", {mem_addr, mem_wdata}, 64'h0);
        chk("reset_rsp_data", {if_rsp_rdata, ls_rsp_rdata}, 64'h0);
        #2 rst = 1'b0;

        // Lone IF read, zero-wait memory.
        q_if.push_back(mk_if(32'h100));
        fix_stall = 0; fix_k = 1; use_fix_data = 1'b1; fix_data = 32'hDEADBEEF;
        drain(50);
        use_fix_data = 1'b0;

        // Both requesters contending: grants must alternate.
        for (int i = 0; i < 2; i++) begin
            q_if.push_back(mk_if(32'h1000 + 32'(i * 4)));
            q_ls.push_back(mk_ls(32'h2000 + 32'(i * 4), i[0], 32'($urandom), 4'hF));
        end
        drain(100);

        // Store held off by the memory for three cycles.
        q_ls.push_back(mk_ls(32'h204, 1'b1, 32'h0000AB00, 4'b0010));
        fix_stall = 3; fix_k = 1;
        drain(50);

        // Memory never answers: timeout error, later replies ignored.
        q_if.push_back(mk_if(32'h300));
        fix_stall = 0; fix_k = 0;
        drain(50);
        repeat (10) cycle();

        // Reset during RSP drops the transaction and restores IF priority.
        q_ls.push_back(mk_ls(32'h400, 1'b0, 32'h0, 4'hF));
        begin
            int n = 0;
            while (!(phase == 2 && rsp_cyc == 2) && n < 20) begin
                cycle();
                n++;
            end
        end
        #2 rst = 1'b1;
        if_req_valid = 1'b1; ls_req_valid = 1'b1; mem_rsp_valid = 1'b0;
        #1;
        chk("rst_mid_ctrl", {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
                             if_rsp_err, ls_rsp_err, mem_req_valid, mem_write, mem_wstrb}, 0);
        chk("rst_mid_data", {mem_addr, mem_wdata}, 64'h0);
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        @(negedge clk);
        #3 rst = 1'b0;
        phase = 0; last_ls = 1'b1; fix_stall = -1; fix_k = -1;
        q_ls.push_back(mk_ls(32'h500, 1'b1, 32'h12345678, 4'h3));
        q_if.push_back(mk_if(32'h504));
        drain(60);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            if (q_if.size() < 2 && $urandom_range(0, 2) == 0)
                q_if.push_back(mk_if(32'($urandom) & 32'hFFFF_FFFC));
            if (q_ls.size() < 2 && $urandom_range(0, 2) == 0)
                q_ls.push_back(mk_ls(32'($urandom) & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                                     32'($urandom), 4'($urandom_range(0, 15))));
            cycle();
        end
        drain(500);
        chk("rsp_queue_empty", 32'(q_rsp.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
